// File: rtl/wb_sequencer.sv
// Multicycle writeback controller: classifies decoded RV32I opcodes, runs the
// data-memory handshake and drives one writeback strobe. Macro WB_PIPELINE_EN enables accept-during-WB.
module wb_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inst_valid,
   output logic       inst_ready,
   input  logic [6:0] opcode,
   input  logic [4:0] rd,
   output logic       mem_req,
   output logic       mem_we,
   input  logic       mem_ack,
   output logic [1:0] mux_sel,
   output logic       reg_we,
   output logic [4:0] reg_waddr,
   output logic       busy,
   output logic       timeout_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MEM  = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   logic [1:0]      state_q, state_d;
   logic [6:0]      opcode_q, opcode_d;
   logic [4:0]      rd_q, rd_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            terr_q, terr_d;
   logic            accept;
   logic            new_direct;
   logic            new_mem;

   assign new_direct = (opcode == OPC_LUI) || (opcode == OPC_OP) ||
                       (opcode == OPC_OP_IMM) || (opcode == OPC_AUIPC);
   assign new_mem    = (opcode == OPC_LOAD) || (opcode == OPC_STORE);

`ifdef WB_PIPELINE_EN
   assign inst_ready = (state_q == S_IDLE) || (state_q == S_WB);
`else
   assign inst_ready = (state_q == S_IDLE);
`endif

   assign accept = inst_valid & inst_ready;

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q;
      terr_d   = terr_q;
      case (state_q)
         S_MEM: begin
            // An ack in the final allowed cycle still completes normally.
            if (mem_ack) begin
               state_d = (opcode_q == OPC_STORE) ? S_IDLE : S_WB;
            end else if (cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
               terr_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Accept only happens in IDLE (or WB when pipelined), so it owns the next state.
      if (accept) begin
         opcode_d = opcode;
         rd_d     = rd;
         cnt_d    = '0;
         if (new_direct) begin
            state_d = S_WB;
         end else if (new_mem) begin
            state_d = S_MEM;
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         opcode_q <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         terr_q   <= terr_d;
      end
   end

   always_comb begin
      mux_sel = 2'b11;
      if (state_q == S_WB) begin
         case (opcode_q)
            OPC_LUI:  mux_sel = 2'b00;
            OPC_LOAD: mux_sel = 2'b10;
            default:  mux_sel = 2'b01;
         endcase
      end
   end

   assign reg_we      = (state_q == S_WB) && (rd_q != 5'd0);
   assign reg_waddr   = (state_q == S_WB) ? rd_q : 5'd0;
   assign mem_req     = (state_q == S_MEM);
   assign mem_we      = (state_q == S_MEM) && (opcode_q == OPC_STORE);
   assign busy        = (state_q != S_IDLE);
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed table-driven bench for wb_sequencer (MEM_TIMEOUT=4), with hand
// sequences for back-to-back issue in both WB_PIPELINE_EN builds.
module tb_wb_sequencer;

   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OPIMM  = 7'b0010011;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] SYS    = 7'b1110011;

`ifdef WB_PIPELINE_EN
   localparam bit PIPE = 1'b1;
`else
   localparam bit PIPE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       inst_valid = 1'b0;
   logic       inst_ready;
   logic [6:0] opcode = '0;
   logic [4:0] rd = '0;
   logic       mem_req;
   logic       mem_we;
   logic       mem_ack = 1'b0;
   logic [1:0] mux_sel;
   logic       reg_we;
   logic [4:0] reg_waddr;
   logic       busy;
   logic       timeout_err;

   wb_sequencer #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .opcode(opcode), .rd(rd), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
      .mux_sel(mux_sel), .reg_we(reg_we), .reg_waddr(reg_waddr), .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // {ready, mem_req, mem_we, mux_sel[1:0], reg_we, reg_waddr[4:0], busy, timeout_err}
   typedef struct {
      logic        rst;
      logic        v;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic        ack;
      logic [12:0] exp;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [12:0] e(bit rdy, bit req, bit we, logic [1:0] sel,
                                     bit rwe, logic [4:0] wa, bit bsy, bit terr);
      return {rdy, req, we, sel, rwe, wa, bsy, terr};
   endfunction

   function automatic logic [12:0] st_i(bit terr);
      return e(1, 0, 0, 2'b11, 0, 5'd0, 0, terr);
   endfunction

   function automatic logic [12:0] st_m(bit we, bit terr);
      return e(0, 1, we, 2'b11, 0, 5'd0, 1, terr);
   endfunction

   function automatic logic [12:0] st_w(logic [1:0] sel, bit rwe, logic [4:0] wa, bit terr);
      return e(PIPE, 0, 0, sel, rwe, wa, 1, terr);
   endfunction

   function automatic void add(bit r, bit v, logic [6:0] op, logic [4:0] d, bit ack,
                               logic [12:0] x);
      vec_t t;
      t.rst = r; t.v = v; t.op = op; t.rd = d; t.ack = ack; t.exp = x;
      vq.push_back(t);
   endfunction

   function automatic logic [12:0] observed();
      return {inst_ready, mem_req, mem_we, mux_sel, reg_we, reg_waddr, busy, timeout_err};
   endfunction

   task automatic check(string name, logic [12:0] act, logic [12:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b (rdy,req,we,sel,rwe,waddr,busy,terr)",
                  name, act, exp);
      end else begin
         $display("ok   %s: %b", name, act);
      end
   endtask

   task automatic drive(bit v, logic [6:0] op, logic [4:0] d, bit ack);
      @(posedge clk);
      #1;
      inst_valid = v; opcode = op; rd = d; mem_ack = ack;
   endtask

   initial begin
      // Reset, LUI rd=5
      add(1, 0, 7'd0, 5'd0, 0, st_i(0));
      add(0, 1, LUI,  5'd5, 0, st_i(0));
      add(0, 0, 7'd0, 5'd0, 0, st_w(2'b00, 1, 5'd5, 0));
      // LOAD rd=7, ack on 3rd MEM cycle; inst_valid in MEM must be ignored
      add(0, 1, LOAD, 5'd7, 0, st_i(0));
      add(0, 0, 7'd0, 5'd0, 0, st_m(0, 0));
      add(0, 1, OP,   5'd1, 0, st_m(0, 0));
      add(0, 0, 7'd0, 5'd0, 1, st_m(0, 0));
      add(0, 0, 7'd0, 5'd0, 0, st_w(2'b10, 1, 5'd7, 0));
      // STORE, ack in first MEM cycle
      add(0, 1, STORE, 5'd3, 0, st_i(0));
      add(0, 0, 7'd0, 5'd0, 1, st_m(1, 0));
      // LOAD timeout (ack in IDLE is ignored)
      add(0, 1, LOAD, 5'd9, 1, st_i(0));
      add(0, 0, 7'd0, 5'd0, 0, st_m(0, 0));
      add(0, 0, 7'd0, 5'd0, 0, st_m(0, 0));
      add(0, 0, 7'd0, 5'd0, 0, st_m(0, 0));
      add(0, 0, 7'd0, 5'd0, 0, st_m(0, 0));
      // LOAD with ack in the final allowed cycle; error stays sticky
      add(0, 1, LOAD, 5'd10, 0, st_i(1));
      add(0, 0, 7'd0, 5'd0, 0, st_m(0, 1));
      add(0, 0, 7'd0, 5'd0, 0, st_m(0, 1));
      add(0, 0, 7'd0, 5'd0, 0, st_m(0, 1));
      add(0, 0, 7'd0, 5'd0, 1, st_m(0, 1));
      add(0, 0, 7'd0, 5'd0, 0, st_w(2'b10, 1, 5'd10, 1));
      // OP rd=0, SYSTEM NOP, OP-IMM, AUIPC
      add(0, 1, OP,   5'd0, 0, st_i(1));
      add(0, 0, 7'd0, 5'd0, 0, st_w(2'b01, 0, 5'd0, 1));
      add(0, 1, SYS,  5'd4, 0, st_i(1));
      add(0, 1, OPIMM, 5'd12, 0, st_i(1));
      add(0, 0, 7'd0, 5'd0, 0, st_w(2'b01, 1, 5'd12, 1));
      add(0, 1, AUIPC, 5'd13, 0, st_i(1));
      add(0, 0, 7'd0, 5'd0, 0, st_w(2'b01, 1, 5'd13, 1));
      // Reset in the middle of a LOAD's MEM phase takes effect before the next edge
      add(0, 1, LOAD, 5'd2, 0, st_i(1));
      add(0, 0, 7'd0, 5'd0, 0, st_m(0, 1));
      add(1, 0, 7'd0, 5'd0, 0, st_i(0));
      add(0, 0, 7'd0, 5'd0, 0, st_i(0));

      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk);
         #1;
         reset = vq[i].rst; inst_valid = vq[i].v; opcode = vq[i].op;
         rd = vq[i].rd; mem_ack = vq[i].ack;
         @(negedge clk);
         check($sformatf("vec%0d", i), observed(), vq[i].exp);
      end

`ifdef WB_PIPELINE_EN
      // Four back-to-back OPs: reg_we high four consecutive cycles
      drive(1, OP, 5'd1, 0);
      @(negedge clk);
      check("pipe_issue", observed(), st_i(0));
      for (int k = 2; k <= 4; k++) begin
         drive(1, OP, 5'(k), 0);
         @(negedge clk);
         check($sformatf("pipe_wb%0d", k - 1), observed(),
               e(1, 0, 0, 2'b01, 1, 5'(k - 1), 1, 0));
      end
      drive(0, 7'd0, 5'd0, 0);
      @(negedge clk);
      check("pipe_wb4", observed(), e(1, 0, 0, 2'b01, 1, 5'd4, 1, 0));
      drive(0, 7'd0, 5'd0, 0);
      @(negedge clk);
      check("pipe_idle", observed(), st_i(0));
`else
      // Held inst_valid: WB refuses the next instruction, two cycles per ALU op
      drive(1, OP, 5'd1, 0);
      @(negedge clk);
      check("b2b_issue1", observed(), st_i(0));
      drive(1, OP, 5'd2, 0);
      @(negedge clk);
      check("b2b_wb1", observed(), e(0, 0, 0, 2'b01, 1, 5'd1, 1, 0));
      drive(1, OP, 5'd2, 0);
      @(negedge clk);
      check("b2b_issue2", observed(), st_i(0));
      drive(0, 7'd0, 5'd0, 0);
      @(negedge clk);
      check("b2b_wb2", observed(), e(0, 0, 0, 2'b01, 1, 5'd2, 1, 0));
      drive(0, 7'd0, 5'd0, 0);
      @(negedge clk);
      check("b2b_idle", observed(), st_i(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
- Multicycle writeback controller for the RV32I core.
- Accepts one decoded instruction at a time and classifies it by opcode.
- Sequences the data-memory handshake for loads and stores.
- Drives the 2-bit writeback-mux select and the register-file write enable/address for exactly one cycle per writing instruction.
- Sits between decode and the register-file/writeback mux.

Parameters:
- MEM_TIMEOUT, 15, max MEM-state cycles without mem_ack before abort (>=1).
- TO_W, $clog2(MEM_TIMEOUT+1), width of the timeout counter.

Ports:
- clk  in  1  single core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_valid  in  1  decoded instruction present.
- inst_ready  out  1  sequencer can accept; transfer when inst_valid & inst_ready at a rising edge.
- opcode  in  7  instruction bits [6:0].
- rd  in  5  destination register.
- mem_req  out  1  data-memory request, held until mem_ack.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req.
- mem_ack  in  1  memory completes the request in this cycle.
- mux_sel  out  2  writeback-mux select: 00 LUI immediate, 01 ALU result, 10 memory data, 11 none.
- reg_we  out  1  register-file write strobe.
- reg_waddr  out  5  register-file write address.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (async, any state):
  - state=IDLE; registered opcode/rd cleared; counter=0.
  - mem_req=0, mem_we=0, reg_we=0, reg_waddr=0, mux_sel=11, busy=0, timeout_err=0, inst_ready=1.
  - Mid-transaction reset drops mem_req immediately; no writeback occurs.
- Opcode classes:
  - 0110111 LUI -> sel 00.
  - 0110011 OP, 0010011 OP-IMM, 0010111 AUIPC -> sel 01.
  - 0000011 LOAD -> memory read, sel 10.
  - 0100011 STORE -> memory write, no writeback.
  - Anything else -> NOP: no memory, no writeback.
- States: IDLE, MEM, WB.
- IDLE:
  - inst_ready=1.
  - On accept, latch opcode and rd.
  - LUI/ALU class -> WB. LOAD/STORE -> MEM with counter=0. NOP -> stays IDLE.
- MEM:
  - mem_req=1; mem_we=1 for STORE only.
  - mem_ack=1: LOAD -> WB; STORE -> IDLE. mem_req deasserts in the following cycle.
  - Otherwise counter increments each cycle.
  - When counter==MEM_TIMEOUT-1 and mem_ack=0: set timeout_err, go IDLE, no writeback.
  - mem_ack in that same final cycle wins; no error.
- WB (exactly one cycle, then IDLE):
  - mux_sel = class select; reg_waddr = latched rd.
  - reg_we=1 unless rd==0; with rd==0, mux_sel is still driven but reg_we=0.
- Outside WB: mux_sel=11, reg_we=0.
- Latency:
  - ALU/LUI: WB in the cycle after acceptance; next accept one cycle later (2 cycles per instruction).
  - LOAD: WB one cycle after the mem_ack cycle.
- Outputs mux_sel, reg_we, reg_waddr, mem_req and mem_we are combinational from state plus latched fields only, never from inst_valid.
- mem_ack outside MEM is ignored.
- timeout_err clears only on reset.

Optional Feature:
- Macro WB_PIPELINE_EN.
- Defined:
  - inst_ready=1 in WB as well as IDLE.
  - An instruction accepted during WB latches its fields and transitions exactly as from IDLE. The current WB still completes with the old rd/select.
  - Back-to-back ALU/LUI sustain 1 instruction/cycle with reg_we continuously high.
- Undefined: inst_ready=1 only in IDLE, as above.

Test Plan:
1. Reset held, then released; LUI with rd=5 presented with inst_valid=1 -> accepted at edge 1; next cycle mux_sel=00, reg_we=1, reg_waddr=5; following cycle mux_sel=11, reg_we=0, inst_ready=1.
2. LOAD rd=7, mem_ack asserted on the 3rd MEM cycle -> mem_req high for exactly 3 cycles with mem_we=0; next cycle mux_sel=10, reg_we=1, reg_waddr=7.
3. STORE, mem_ack after 1 cycle -> mem_req=1 and mem_we=1 for 1 cycle; return to IDLE with reg_we never asserted and mux_sel stays 11.
4. LOAD with no mem_ack, MEM_TIMEOUT=4 -> mem_req high exactly 4 cycles, then timeout_err=1 (sticky), no reg_we. Repeat with mem_ack on the 4th cycle -> no error and a normal WB.
5. OP with rd=0 -> WB cycle shows mux_sel=01, reg_we=0. Opcode 1110011 -> no state change beyond IDLE, busy stays 0.
6. Assert reset during MEM of a LOAD -> mem_req=0 in the same cycle, before the next clock edge; all outputs at reset values. With WB_PIPELINE_EN: 4 back-to-back OP instructions (rd=1..4) -> reg_we high 4 consecutive cycles with reg_waddr 1,2,3,4.
